// File: rtl/alu_exec_stage_pkg.sv
// alu_exec_stage_pkg
//   Shared definitions for the execute stage: ALU operation codes, default
//   datapath widths and the control-bit bundle carried into EX/MEM,
//   including its bubble value.
//   Optional build macro used by the stage: ALU_OVF_TRAP_EN.
package alu_exec_stage_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;

  // Operation codes shared with the ALU control decoder. All sixteen
  // encodings of the 4-bit field are assigned; the ALU still maps any
  // code it does not recognise to a zero result.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_SLT  = 4'd4,
    ALU_SLLV = 4'd5,
    ALU_NOR  = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_SRLV = 4'd8,
    ALU_SRAV = 4'd9,
    ALU_SLL  = 4'd10,
    ALU_SRL  = 4'd11,
    ALU_SRA  = 4'd12,
    ALU_ADDU = 4'd13,
    ALU_SUBU = 4'd14,
    ALU_SLTU = 4'd15
  } alu_op_e;

  // Control bits forwarded from ID/EX into EX/MEM.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctrl_bits_t;

  // Value of the control bits in an empty (bubble) slot.
  localparam ctrl_bits_t BUBBLE_CTRL = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0};

endpackage

// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if
//   Bundle between the ID/EX side (master) and the execute stage (slave).
//   Master drives pipeline control (stall, flush, exc_ack) and the ID/EX
//   slot contents; the stage drives the EX/MEM register contents and the
//   overflow exception outputs (ovf_exc, epc).
interface alu_exec_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  // pipeline control
  logic                  stall;
  logic                  flush;
  logic                  exc_ack;
  // ID/EX slot
  logic                  in_valid;
  logic [3:0]            alu_ctrl;
  logic [DATA_W-1:0]     op_a;
  logic [DATA_W-1:0]     op_b;
  logic [4:0]            shamt;
  logic [DATA_W-1:0]     pc_in;
  logic [REG_ADDR_W-1:0] rd_in;
  logic                  reg_write_in;
  logic                  mem_read_in;
  logic                  mem_write_in;
  logic [DATA_W-1:0]     store_data_in;
  // EX/MEM slot
  logic                  out_valid;
  logic [DATA_W-1:0]     alu_result;
  logic                  zero;
  logic [REG_ADDR_W-1:0] rd_out;
  logic                  reg_write_out;
  logic                  mem_read_out;
  logic                  mem_write_out;
  logic [DATA_W-1:0]     store_data_out;
  // exception
  logic                  ovf_exc;
  logic [DATA_W-1:0]     epc;

  modport master (
    output stall, flush, exc_ack, in_valid, alu_ctrl, op_a, op_b, shamt,
           pc_in, rd_in, reg_write_in, mem_read_in, mem_write_in, store_data_in,
    input  out_valid, alu_result, zero, rd_out, reg_write_out, mem_read_out,
           mem_write_out, store_data_out, ovf_exc, epc
  );

  modport slave (
    input  stall, flush, exc_ack, in_valid, alu_ctrl, op_a, op_b, shamt,
           pc_in, rd_in, reg_write_in, mem_read_in, mem_write_in, store_data_in,
    output out_valid, alu_result, zero, rd_out, reg_write_out, mem_read_out,
           mem_write_out, store_data_out, ovf_exc, epc
  );
endinterface

// File: rtl/alu_exec_stage_alu_core.sv
// alu_core
//   Purely combinational ALU for the execute stage.
//   Ports:
//     alu_ctrl in  4       operation code (alu_op_e)
//     op_a     in  DATA_W  rs operand; op_a[4:0] is the variable shift amount
//     op_b     in  DATA_W  rt operand / immediate; the value being shifted
//     shamt    in  5       constant shift amount for SLL/SRL/SRA
//     result   out DATA_W  operation result (0 for unrecognised codes)
//     ovf      out 1       signed overflow of ADD/SUB (never set for ADDU/SUBU)
module alu_core
  import alu_exec_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [4:0]        shamt,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              add_ovf;
  logic              sub_ovf;
  logic              lt_signed;
  logic              lt_unsigned;

  assign sum         = op_a + op_b;
  assign diff        = op_a - op_b;
  assign lt_signed   = $signed(op_a) < $signed(op_b);
  assign lt_unsigned = op_a < op_b;

  // Two's-complement overflow: operands that agree in sign (add) or differ
  // in sign (sub) producing a result whose sign differs from op_a.
  assign add_ovf = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum[DATA_W-1]  != op_a[DATA_W-1]);
  assign sub_ovf = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (diff[DATA_W-1] != op_a[DATA_W-1]);

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (alu_ctrl)
      ALU_ADD:  begin result = sum;  ovf = add_ovf; end
      ALU_SUB:  begin result = diff; ovf = sub_ovf; end
      ALU_ADDU: result = sum;
      ALU_SUBU: result = diff;
      ALU_AND:  result = op_a & op_b;
      ALU_OR:   result = op_a | op_b;
      ALU_XOR:  result = op_a ^ op_b;
      ALU_NOR:  result = ~(op_a | op_b);
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, lt_signed};
      ALU_SLTU: result = {{(DATA_W-1){1'b0}}, lt_unsigned};
      ALU_SLL:  result = op_b << shamt;
      ALU_SRL:  result = op_b >> shamt;
      ALU_SRA:  result = $unsigned($signed(op_b) >>> shamt);
      ALU_SLLV: result = op_b << op_a[4:0];
      ALU_SRLV: result = op_b >> op_a[4:0];
      ALU_SRAV: result = $unsigned($signed(op_b) >>> op_a[4:0]);
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage
//   Execute stage of the pipeline: runs the ALU on the ID/EX slot and
//   registers the result plus forwarded control bits into EX/MEM.
//   Update priority is flush > stall > capture. One cycle latency.
//   Ports:
//     clk    in  1  rising-edge clock
//     reset  in  1  asynchronous active-high reset; clears every output
//     bus    slave  alu_exec_stage_if (ID/EX inputs, EX/MEM outputs,
//                   stall/flush/exc_ack, ovf_exc/epc)
//   Build option ALU_OVF_TRAP_EN: signed overflow on ADD/SUB of a captured
//   valid instruction suppresses reg_write_out and raises the sticky
//   ovf_exc flag with epc = pc_in. Without it ovf_exc/epc are tied to 0.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  alu_exec_stage_if.slave   bus
);

  logic [DATA_W-1:0] core_result;
  logic              core_ovf;
  logic              trap;

  logic                  out_valid_reg;
  logic [DATA_W-1:0]     result_reg;
  logic                  zero_reg;
  logic [REG_ADDR_W-1:0] rd_reg;
  ctrl_bits_t            ctrl_reg;
  ctrl_bits_t            ctrl_next;
  logic [DATA_W-1:0]     store_data_reg;

  alu_core #(.DATA_W(DATA_W)) u_alu_core (
    .alu_ctrl (bus.alu_ctrl),
    .op_a     (bus.op_a),
    .op_b     (bus.op_b),
    .shamt    (bus.shamt),
    .result   (core_result),
    .ovf      (core_ovf)
  );

  // Empty slots carry bubble control bits; a trapping instruction keeps its
  // result but must not write the register file.
  always_comb begin
    ctrl_next = BUBBLE_CTRL;
    if (bus.in_valid) begin
      ctrl_next.reg_write = bus.reg_write_in & ~trap;
      ctrl_next.mem_read  = bus.mem_read_in;
      ctrl_next.mem_write = bus.mem_write_in;
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg  <= 1'b0;
      result_reg     <= '0;
      zero_reg       <= 1'b0;
      rd_reg         <= '0;
      ctrl_reg       <= BUBBLE_CTRL;
      store_data_reg <= '0;
    end else if (bus.flush) begin
      out_valid_reg  <= 1'b0;
      result_reg     <= '0;
      zero_reg       <= 1'b0;
      rd_reg         <= '0;
      ctrl_reg       <= BUBBLE_CTRL;
      store_data_reg <= '0;
    end else if (!bus.stall) begin
      out_valid_reg  <= bus.in_valid;
      result_reg     <= core_result;
      zero_reg       <= (core_result == '0);
      rd_reg         <= bus.rd_in;
      ctrl_reg       <= ctrl_next;
      store_data_reg <= bus.store_data_in;
    end
  end

`ifdef ALU_OVF_TRAP_EN
  logic              ovf_exc_reg;
  logic [DATA_W-1:0] epc_reg;

  // Only an instruction actually entering EX/MEM can trap.
  assign trap = bus.in_valid & core_ovf & ~bus.flush & ~bus.stall;

  // Sticky flag: a new trap beats a same-cycle acknowledge. epc records the
  // first unacknowledged trap; an acknowledge in the same cycle as a new
  // trap retires the old one, so the new PC is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_exc_reg <= 1'b0;
      epc_reg     <= '0;
    end else if (trap) begin
      ovf_exc_reg <= 1'b1;
      if (!ovf_exc_reg || bus.exc_ack) begin
        epc_reg <= bus.pc_in;
      end
    end else if (bus.exc_ack) begin
      ovf_exc_reg <= 1'b0;
    end
  end

  assign bus.ovf_exc = ovf_exc_reg;
  assign bus.epc     = epc_reg;
`else
  logic unused_exc_inputs;

  assign trap              = 1'b0;
  assign bus.ovf_exc       = 1'b0;
  assign bus.epc           = '0;
  assign unused_exc_inputs = ^{core_ovf, bus.exc_ack, bus.pc_in};
`endif

  assign bus.out_valid      = out_valid_reg;
  assign bus.alu_result     = result_reg;
  assign bus.zero           = zero_reg;
  assign bus.rd_out         = rd_reg;
  assign bus.reg_write_out  = ctrl_reg.reg_write;
  assign bus.mem_read_out   = ctrl_reg.mem_read;
  assign bus.mem_write_out  = ctrl_reg.mem_write;
  assign bus.store_data_out = store_data_reg;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage
//   Scoreboard bench for alu_exec_stage. Each driven slot pushes its
//   expected EX/MEM contents; the entry is popped and compared one cycle
//   later. Build with or without ALU_OVF_TRAP_EN.
module tb_alu_exec_stage;
  import alu_exec_stage_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic        zero;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] sd;
    logic        exc;
    logic [31:0] epc;
  } out_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
  } op_vec_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic        ack;
    logic [31:0] res;
    logic        rw;
    logic        exc;
    logic [31:0] epc;
  } ovf_vec_t;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  out_t sb[$];
  out_t got;
  out_t exp_o;
  logic        exp_exc;
  logic [31:0] exp_epc;

  alu_exec_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

  alu_exec_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  op_vec_t ops_tbl [0:15] = '{
    '{ALU_ADD,  32'd5,        32'd7,        5'd0,  32'd12},
    '{ALU_SUB,  32'd9,        32'd9,        5'd0,  32'd0},
    '{ALU_SRA,  32'd0,        32'hF000_0000, 5'd4, 32'hFF00_0000},
    '{ALU_SLTU, 32'd1,        32'hFFFF_FFFF, 5'd0, 32'd1},
    '{ALU_SLT,  32'd3,        32'd3,        5'd0,  32'd0},
    '{ALU_SLLV, 32'h0000_0023, 32'd1,       5'd0,  32'd8},
    '{ALU_SLT,  32'hFFFF_FFFF, 32'd1,       5'd0,  32'd1},
    '{ALU_NOR,  32'd0,        32'd0,        5'd0,  32'hFFFF_FFFF},
    '{ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000},
    '{ALU_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hFFF0_FFF0},
    '{ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0FF0_0FF0},
    '{ALU_SRL,  32'd0,        32'h8000_0000, 5'd31, 32'd1},
    '{ALU_SLL,  32'd0,        32'd3,        5'd4,  32'h30},
    '{ALU_SRAV, 32'd4,        32'h8000_0000, 5'd0, 32'hF800_0000},
    '{ALU_SRLV, 32'h21,       32'h10,       5'd9,  32'd8},
    '{ALU_ADDU, 32'hFFFF_FFFF, 32'd1,       5'd0,  32'd0}
  };

`ifdef ALU_OVF_TRAP_EN
  ovf_vec_t ovf_tbl [0:6] = '{
    '{ALU_ADD,  32'h7FFF_FFFF, 32'd1, 32'h40, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 32'h40},
    '{ALU_ADD,  32'h7FFF_FFFF, 32'd1, 32'h44, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 32'h40},
    '{ALU_ADDU, 32'd1,         32'd1, 32'h48, 1'b1, 32'd2,         1'b1, 1'b0, 32'h40},
    '{ALU_ADDU, 32'h7FFF_FFFF, 32'd1, 32'h4C, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 32'h40},
    '{ALU_SUB,  32'h8000_0000, 32'd1, 32'h50, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 32'h50},
    '{ALU_ADD,  32'h7FFF_FFFF, 32'd1, 32'h54, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 32'h54},
    '{ALU_SUBU, 32'd0,         32'd1, 32'h58, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h54}
  };
`else
  ovf_vec_t ovf_tbl [0:6] = '{
    '{ALU_ADD,  32'h7FFF_FFFF, 32'd1, 32'h40, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 32'h0},
    '{ALU_ADD,  32'h7FFF_FFFF, 32'd1, 32'h44, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 32'h0},
    '{ALU_ADDU, 32'd1,         32'd1, 32'h48, 1'b1, 32'd2,         1'b1, 1'b0, 32'h0},
    '{ALU_ADDU, 32'h7FFF_FFFF, 32'd1, 32'h4C, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 32'h0},
    '{ALU_SUB,  32'h8000_0000, 32'd1, 32'h50, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'h0},
    '{ALU_ADD,  32'h7FFF_FFFF, 32'd1, 32'h54, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 32'h0},
    '{ALU_SUBU, 32'd0,         32'd1, 32'h58, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0}
  };
`endif

  function automatic out_t sample();
    out_t s;
    s.valid  = bus.out_valid;
    s.result = bus.alu_result;
    s.zero   = bus.zero;
    s.rd     = bus.rd_out;
    s.rw     = bus.reg_write_out;
    s.mr     = bus.mem_read_out;
    s.mw     = bus.mem_write_out;
    s.sd     = bus.store_data_out;
    s.exc    = bus.ovf_exc;
    s.epc    = bus.epc;
    return s;
  endfunction

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input logic [31:0] pc,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic mw, input logic [31:0] sd);
    bus.in_valid      = v;
    bus.alu_ctrl      = op;
    bus.op_a          = a;
    bus.op_b          = b;
    bus.shamt         = sh;
    bus.pc_in         = pc;
    bus.rd_in         = rd;
    bus.reg_write_in  = rw;
    bus.mem_read_in   = mr;
    bus.mem_write_in  = mw;
    bus.store_data_in = sd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.exc_ack = 1'b0;
    drive(1'b0, 4'd0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    exp_exc = 1'b0;
    exp_epc = '0;
    #2;
    got = sample();
    tests_run++;
    if (got !== out_t'(0)) begin
      tests_failed++;
      $display("FAIL reset_state got=%h exp=%h", got, out_t'(0));
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_ops();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, ops_tbl[i].op, ops_tbl[i].a, ops_tbl[i].b, ops_tbl[i].sh, 32'h100 + i,
            5'(i + 1), 1'b1, i[0], i[1], 32'hA000_0000 + i);
      sb.push_back('{valid: 1'b1, result: ops_tbl[i].res, zero: (ops_tbl[i].res == 32'd0),
                     rd: 5'(i + 1), rw: 1'b1, mr: i[0], mw: i[1],
                     sd: 32'hA000_0000 + i, exc: exp_exc, epc: exp_epc});
      @(posedge clk);
      #1;
      got = sample();
      exp_o = sb.pop_front();
      tests_run++;
      if (got !== exp_o) begin
        tests_failed++;
        $display("FAIL op_%0d (ctrl %0d) got=%h exp=%h", i, ops_tbl[i].op, got, exp_o);
      end
    end
  endtask

  // in_valid=0: data still captured, control bits forced to bubble, no trap.
  task automatic test_invalid();
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        drive(1'b0, ALU_ADD, 32'd2, 32'd3, 5'd0, 32'h200, 5'd7, 1'b1, 1'b1, 1'b1, 32'h55);
        sb.push_back('{valid: 1'b0, result: 32'd5, zero: 1'b0, rd: 5'd7, rw: 1'b0, mr: 1'b0,
                       mw: 1'b0, sd: 32'h55, exc: exp_exc, epc: exp_epc});
      end else begin
        drive(1'b0, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h204, 5'd8, 1'b1, 1'b0, 1'b1, 32'h66);
        sb.push_back('{valid: 1'b0, result: 32'h8000_0000, zero: 1'b0, rd: 5'd8, rw: 1'b0,
                       mr: 1'b0, mw: 1'b0, sd: 32'h66, exc: exp_exc, epc: exp_epc});
      end
      @(posedge clk);
      #1;
      got = sample();
      exp_o = sb.pop_front();
      tests_run++;
      if (got !== exp_o) begin
        tests_failed++;
        $display("FAIL invalid_slot_%0d got=%h exp=%h", i, got, exp_o);
      end
    end
  endtask

  // One capture, three stalled cycles with changing inputs, then stall+flush.
  task automatic test_stall_flush();
    out_t held;
    held = '{valid: 1'b1, result: 32'd30, zero: 1'b0, rd: 5'd9, rw: 1'b1, mr: 1'b0,
             mw: 1'b1, sd: 32'h1234_5678, exc: exp_exc, epc: exp_epc};
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin
          drive(1'b1, ALU_ADDU, 32'd10, 32'd20, 5'd0, 32'h300, 5'd9, 1'b1, 1'b0, 1'b1, 32'h1234_5678);
          sb.push_back(held);
        end
        1, 2, 3: begin
          bus.stall = 1'b1;
          drive(1'b1, ALU_SUBU, 32'(i), 32'd0, 5'd0, 32'h304, 5'(i), 1'b0, 1'b1, 1'b0, 32'(i));
          sb.push_back(held);
        end
        default: begin
          bus.stall = 1'b1;
          bus.flush = 1'b1;
          drive(1'b1, ALU_ADDU, 32'd1, 32'd1, 5'd0, 32'h308, 5'd3, 1'b1, 1'b1, 1'b1, 32'd7);
          sb.push_back('{valid: 1'b0, result: 32'd0, zero: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0,
                         mw: 1'b0, sd: 32'd0, exc: exp_exc, epc: exp_epc});
        end
      endcase
      @(posedge clk);
      #1;
      got = sample();
      exp_o = sb.pop_front();
      tests_run++;
      if (got !== exp_o) begin
        tests_failed++;
        $display("FAIL stall_flush_step_%0d got=%h exp=%h", i, got, exp_o);
      end
    end
    bus.stall = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 7; i++) begin
      bus.exc_ack = ovf_tbl[i].ack;
      drive(1'b1, ovf_tbl[i].op, ovf_tbl[i].a, ovf_tbl[i].b, 5'd0, ovf_tbl[i].pc,
            5'd12, 1'b1, 1'b0, 1'b0, 32'hCAFE_0000 + i);
      exp_exc = ovf_tbl[i].exc;
      exp_epc = ovf_tbl[i].epc;
      sb.push_back('{valid: 1'b1, result: ovf_tbl[i].res, zero: 1'b0, rd: 5'd12,
                     rw: ovf_tbl[i].rw, mr: 1'b0, mw: 1'b0, sd: 32'hCAFE_0000 + i,
                     exc: exp_exc, epc: exp_epc});
      @(posedge clk);
      #1;
      got = sample();
      exp_o = sb.pop_front();
      tests_run++;
      if (got !== exp_o) begin
        tests_failed++;
        $display("FAIL overflow_%0d got=%h exp=%h", i, got, exp_o);
      end
    end
    bus.exc_ack = 1'b0;
  endtask

  // Consecutive slots with random operands for a few well-defined ops.
  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom;
      case (i % 3)
        0: begin r = a ^ b;       drive(1'b1, ALU_XOR,  a, b, 5'd0, 32'h400, 5'(i), 1'b1, 1'b0, 1'b0, a); end
        1: begin r = a - b;       drive(1'b1, ALU_SUBU, a, b, 5'd0, 32'h400, 5'(i), 1'b1, 1'b0, 1'b0, a); end
        default: begin r = ~(a | b); drive(1'b1, ALU_NOR, a, b, 5'd0, 32'h400, 5'(i), 1'b1, 1'b0, 1'b0, a); end
      endcase
      sb.push_back('{valid: 1'b1, result: r, zero: (r == 32'd0), rd: 5'(i), rw: 1'b1, mr: 1'b0,
                     mw: 1'b0, sd: a, exc: exp_exc, epc: exp_epc});
      @(posedge clk);
      #1;
      got = sample();
      exp_o = sb.pop_front();
      tests_run++;
      if (got !== exp_o) begin
        tests_failed++;
        $display("FAIL back_to_back_%0d got=%h exp=%h", i, got, exp_o);
      end
    end
  endtask

  // Load a valid (and, with the trap enabled, overflowing) slot, then reset
  // between edges and check everything clears without waiting for clk.
  task automatic test_reset_midstream();
    drive(1'b1, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h60, 5'd4, 1'b1, 1'b0, 1'b0, 32'h77);
`ifdef ALU_OVF_TRAP_EN
    exp_exc = 1'b1;
    exp_epc = 32'h60;
    sb.push_back('{valid: 1'b1, result: 32'h8000_0000, zero: 1'b0, rd: 5'd4, rw: 1'b0,
                   mr: 1'b0, mw: 1'b0, sd: 32'h77, exc: exp_exc, epc: exp_epc});
`else
    sb.push_back('{valid: 1'b1, result: 32'h8000_0000, zero: 1'b0, rd: 5'd4, rw: 1'b1,
                   mr: 1'b0, mw: 1'b0, sd: 32'h77, exc: exp_exc, epc: exp_epc});
`endif
    @(posedge clk);
    #1;
    got = sample();
    exp_o = sb.pop_front();
    tests_run++;
    if (got !== exp_o) begin
      tests_failed++;
      $display("FAIL pre_reset_load got=%h exp=%h", got, exp_o);
    end
    #2;
    reset = 1'b1;
    #1;
    got = sample();
    exp_exc = 1'b0;
    exp_epc = '0;
    tests_run++;
    if (got !== out_t'(0)) begin
      tests_failed++;
      $display("FAIL async_reset got=%h exp=%h", got, out_t'(0));
    end
    #2;
    reset = 1'b0;
    drive(1'b0, 4'd0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_ops();
    test_invalid();
    test_stall_flush();
    test_overflow();
    test_back_to_back();
    test_reset_midstream();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain got=%0d entries exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
